// File: rtl/program_loader.sv
// program_loader: streams a LEN/payload/CHK frame into memory while holding the CPU, then releases it
//  clk          system clock
//  rst_n        asynchronous active-low reset
//  i_valid      source has a byte on i_data
//  i_data       stream byte
//  o_ready      loader accepts i_data this cycle
//  o_mem_addr   memory write address
//  o_mem_din    memory write data
//  o_mem_we     memory write enable, one cycle per payload byte
//  o_cpu_hold   processor stalled while high
//  o_done       load complete with good checksum (sticky)
//  o_error      checksum mismatch (sticky)
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic              o_mem_we,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_CHK, S_RUN, S_ERR} state_t;
  state_t            r_state;
  logic              r_ready, r_we, r_hold, r_done, r_error;
  logic [ADDR_W-1:0] r_addr, r_ptr;
  logic [DATA_W-1:0] r_din, r_sum;
  logic [DATA_W:0]   r_cnt;
  logic              w_acc;
  logic [DATA_W-1:0] w_chk;
  assign w_acc = i_valid & r_ready;
  assign w_chk = r_sum + i_data;
  // extra top bit lets a LEN byte of zero stand for a full 2^DATA_W payload
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_LEN;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_din   <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ptr   <= BASE_ADDR;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LEN: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            r_cnt   <= {~|i_data, i_data};
            r_sum   <= '0;
            r_ptr   <= BASE_ADDR;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: if (w_acc) begin
          r_we    <= 1'b1;
          r_din   <= i_data;
          r_addr  <= r_ptr;
          r_ptr   <= r_ptr + 1'b1;
          r_sum   <= w_chk;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == {{DATA_W{1'b0}}, 1'b1}) ? S_CHK : S_LOAD;
        end
        S_CHK: if (w_acc) begin
          r_ready <= 1'b0;
          r_state <= (w_chk == '0) ? S_RUN : S_ERR;
          r_hold  <= (w_chk != '0);
          r_done  <= (w_chk == '0);
          r_error <= (w_chk != '0);
        end
        default: r_ready <= 1'b0;
      endcase
    end
  assign o_ready    = r_ready;
  assign o_mem_addr = r_addr;
  assign o_mem_din  = r_din;
  assign o_mem_we   = r_we;
  assign o_cpu_hold = r_hold;
  assign o_done     = r_done;
  assign o_error    = r_error;
endmodule
